prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 178 +++++++++++++++++
 tb/tb_prog_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed, checksummed byte stream and writes
// it into instruction memory as 32-bit words. When the whole stream has been
// taken in and the checksum matches, it raises a level start signal for the core.
//
// Stream format: LEN_LO, LEN_HI, then N words of 4 bytes each (little-endian),
// then one checksum byte equal to the XOR of all payload bytes.
//
// Handshake: a byte is consumed on a rising edge only when rx_valid and
// rx_ready are both high. A cycle with rx_valid low leaves all state untouched.
// rx_ready does not depend on rx_valid.
module prog_loader #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        start,
    output logic        busy,
    output logic        err,
    output logic [15:0] word_count,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CHK    = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        ready_en;    // low only while in reset, so rx_ready stays low then
    logic        accept;
    logic [7:0]  len_lo;
    logic [15:0] len_n;
    logic [15:0] len_new;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;    // bytes 0..2 of the word being assembled
    logic [7:0]  checksum;
    logic [31:0] next_addr;
    logic [15:0] word_cnt;
    logic        word_done;   // this edge accepts the 4th byte of a word
    logic        last_word;
    logic        start_q;
    logic        err_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    assign accept    = rx_valid && rx_ready;
    assign len_new   = {rx_data, len_lo};
    assign word_done = accept && (state == S_DATA) && (byte_idx == 2'd3);
    assign last_word = (word_cnt == (len_n - 16'd1));

    assign rx_ready   = ready_en && (state != S_DONE) && (state != S_ERROR);
    assign busy       = (state == S_LEN_HI) || (state == S_DATA) || (state == S_CHK);
    assign start      = start_q;
    assign err        = err_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = word_cnt;
    assign dbg_state  = state;

    // State register; reset always restarts parsing from LEN_LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; DONE and ERROR hold until reset.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) next_state = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) begin
                    if (len_new == 16'd0) begin
                        next_state = S_CHK;
                    end else if (32'(len_new) > MAX_WORDS) begin
                        next_state = S_ERROR;
                    end else begin
                        next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_done && last_word) next_state = S_CHK;
            end
            S_CHK: begin
                if (accept) begin
                    next_state = (rx_data == checksum) ? S_DONE : S_ERROR;
                end
            end
            S_DONE:  next_state = S_DONE;
            S_ERROR: next_state = S_ERROR;
            default: next_state = S_IDLE;
        endcase
    end

    // Stream parsing: length capture, word assembly and the running checksum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_lo   <= 8'h00;
            len_n    <= 16'h0000;
            byte_idx <= 2'd0;
            word_buf <= 24'h000000;
            checksum <= 8'h00;
        end else if (accept) begin
            case (state)
                S_IDLE:   len_lo <= rx_data;
                S_LEN_HI: len_n  <= len_new;
                S_DATA: begin
                    checksum <= checksum ^ rx_data;
                    byte_idx <= byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0:    word_buf[7:0]   <= rx_data;
                        2'd1:    word_buf[15:8]  <= rx_data;
                        2'd2:    word_buf[23:16] <= rx_data;
                        default: word_buf        <= word_buf;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Instruction-memory write port: one registered strobe per completed word.
    // Address and data hold their last values between strobes; the address
    // counter wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q      <= 1'b0;
            addr_q    <= ADDR_BASE;
            wdata_q   <= 32'h0000_0000;
            next_addr <= ADDR_BASE;
            word_cnt  <= 16'h0000;
        end else begin
            we_q <= word_done;
            if (word_done) begin
                addr_q    <= next_addr;
                wdata_q   <= {rx_data, word_buf};
                next_addr <= next_addr + 32'd4;
                word_cnt  <= word_cnt + 16'd1;
            end
        end
    end

    // Status flags: ready after the first edge out of reset, start one cycle
    // after DONE is entered, err together with the entry into ERROR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en <= 1'b0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            start_q  <= start_q || (state == S_DONE);
            err_q    <= err_q || (next_state == S_ERROR);
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader. Expected memory writes are queued when a
// stream is issued; a negedge monitor pops and compares on every imem_we.
module tb_prog_loader;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        start;
    logic        busy;
    logic        err;
    logic [15:0] word_count;
    logic [2:0]  dbg_state;

    int n_tests;
    int n_fail;

    logic [63:0] exp_q[$];    // {addr, data}
    logic [7:0]  stim[$];

    prog_loader #(
        .ADDR_BASE (32'h0000_0000),
        .MAX_WORDS (1024)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .start      (start),
        .busy       (busy),
        .err        (err),
        .word_count (word_count),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && imem_we === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected none",
                         imem_addr, imem_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL write: got addr 0x%08h data 0x%08h expected addr 0x%08h data 0x%08h",
                             imem_addr, imem_wdata, e[63:32], e[31:0]);
                end
            end
        end
    end

    // Driver: present one byte after gap idle cycles, hold until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (rx_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got rx_ready=%b expected 1", rx_ready);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_all(input int gap);
        foreach (stim[i]) send_byte(stim[i], gap);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic push_prog();
        exp_q.push_back({32'h0000_0000, 32'h0050_0093});
        exp_q.push_back({32'h0000_0004, 32'h0010_0113});
    endtask

    task automatic check_drained(input string name);
        repeat (3) @(posedge clk);
        #1;
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset    = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_imem_we", imem_we, 0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_imem_wdata", imem_wdata, 32'h0);
        check("rst_start", start, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_word_count", word_count, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", rx_ready, 1);

        // Two-word program, good checksum
        push_prog();
        stim = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                 8'h13, 8'h01, 8'h10, 8'h00, 8'hC1};
        send_byte(stim[0], 0);
        check("busy_after_len_lo", busy, 1);
        for (int i = 1; i < stim.size(); i++) send_byte(stim[i], 0);
        check("ok_start_not_yet", start, 0);
        check("ok_busy_clear", busy, 0);
        check("ok_rx_ready_low", rx_ready, 0);
        @(posedge clk);
        #1;
        check("ok_start", start, 1);
        check("ok_err", err, 0);
        check("ok_word_count", word_count, 2);
        check("ok_addr_hold", imem_addr, 32'h4);
        check("ok_wdata_hold", imem_wdata, 32'h0010_0113);
        check_drained("ok_writes_seen");

        // Bad checksum: writes still happen, then error
        do_reset();
        push_prog();
        stim[10] = 8'hC0;
        send_all(0);
        check("bad_err", err, 1);
        check("bad_start", start, 0);
        check("bad_rx_ready", rx_ready, 0);
        check("bad_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("bad_start_stays_low", start, 0);
        check("bad_err_sticky", err, 1);
        check("bad_word_count", word_count, 2);
        check_drained("bad_writes_seen");

        // Empty program
        do_reset();
        stim = '{8'h00, 8'h00, 8'h00};
        send_all(0);
        check("empty_start_not_yet", start, 0);
        @(posedge clk);
        #1;
        check("empty_start", start, 1);
        check("empty_word_count", word_count, 0);
        check("empty_err", err, 0);
        check_drained("empty_no_writes");

        // Length one over the limit
        do_reset();
        stim = '{8'h01, 8'h04};
        send_all(0);
        check("len_err", err, 1);
        check("len_state_error", dbg_state, 5);
        check("len_rx_ready", rx_ready, 0);
        check("len_word_count", word_count, 0);
        @(posedge clk);
        #1;
        check("len_start", start, 0);
        check_drained("len_no_writes");

        // Two-word program with 3 idle cycles between bytes
        do_reset();
        push_prog();
        stim = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                 8'h13, 8'h01, 8'h10, 8'h00, 8'hC1};
        send_all(3);
        @(posedge clk);
        #1;
        check("gap_start", start, 1);
        check("gap_word_count", word_count, 2);
        check("gap_err", err, 0);
        check_drained("gap_writes_seen");

        // Reset in the middle of the second word, then replay
        do_reset();
        exp_q.push_back({32'h0000_0000, 32'h0050_0093});
        stim = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13};
        send_all(0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_imem_we", imem_we, 0);
        check("mid_rst_word_count", word_count, 0);
        check("mid_rst_addr", imem_addr, 32'h0);
        check("mid_rst_wdata", imem_wdata, 32'h0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rx_ready", rx_ready, 0);
        check("mid_rst_state", dbg_state, 0);
        @(negedge clk);
        reset = 1'b1;
        check_drained("mid_rst_partial_dropped");
        push_prog();
        stim = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                 8'h13, 8'h01, 8'h10, 8'h00, 8'hC1};
        send_all(0);
        @(posedge clk);
        #1;
        check("replay_start", start, 1);
        check("replay_word_count", word_count, 2);
        check("replay_err", err, 0);
        check_drained("replay_writes_seen");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
